// File: rtl/cpu_runctl.sv
// Run/halt/single-step controller for the 8-bit core: gates architectural
// write enables, handles breakpoints, termination and instruction counting.
module cpu_runctl #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  pc_next,
    input  logic             pc_we_in,
    input  logic             reg_we_in,
    input  logic             mem_we_in,
    output logic             pc_we_out,
    output logic             reg_we_out,
    output logic             mem_we_out,
    output logic [1:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic             done,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t cur, nxt;
    logic   skip_bp, skip_nxt;
    logic   hit_nxt;
    logic   bp_stop, exec, self_loop;

    assign bp_stop   = bp_en && (pc == bp_addr) && !skip_bp;
    assign exec      = ((cur == S_RUN) && !bp_stop) || (cur == S_STEP);
    assign self_loop = exec && pc_we_in && (pc_next == pc);

    assign pc_we_out  = pc_we_in  && exec;
    assign reg_we_out = reg_we_in && exec;
    assign mem_we_out = mem_we_in && exec;

    assign state  = cur;
    assign halted = (cur == S_HALT) || (cur == S_DONE);
    assign done   = (cur == S_DONE);

    always_comb begin
        nxt      = cur;
        skip_nxt = skip_bp;
        hit_nxt  = bp_hit;
        // skip_bp covers only the first executed instruction after resuming
        if (exec)
            skip_nxt = 1'b0;
        unique case (cur)
            S_HALT: begin
                if (run_req) begin
                    nxt      = S_RUN;
                    skip_nxt = 1'b1;
                    hit_nxt  = 1'b0;
                end else if (step_req) begin
                    nxt      = S_STEP;
                    skip_nxt = 1'b1;
                    hit_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                if (self_loop) begin
                    nxt = S_DONE;
                end else if (bp_stop) begin
                    nxt     = S_HALT;
                    hit_nxt = 1'b1;
                end else if (halt_req) begin
                    nxt = S_HALT;
                end
            end
            S_STEP: begin
                nxt = self_loop ? S_DONE : S_HALT;
            end
            S_DONE: begin
                nxt = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur     <= S_HALT;
            skip_bp <= 1'b0;
            bp_hit  <= 1'b0;
        end else begin
            cur     <= nxt;
            skip_bp <= skip_nxt;
            bp_hit  <= hit_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            icount <= '0;
        else if (exec && (icount != {CNT_W{1'b1}}))
            icount <= icount + 1'b1;
    end

endmodule

// File: tb/tb_cpu_runctl.sv
// Self-checking bench for cpu_runctl with a sequential-pc program model.
module tb_cpu_runctl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
    logic       bp_en = 1'b0;
    logic [7:0] bp_addr = 8'h00;
    logic [7:0] pc_m;
    logic [7:0] pc_next;
    logic       pc_we_in, reg_we_in, mem_we_in;
    logic       pc_we_out, reg_we_out, mem_we_out;
    logic [1:0] state;
    logic       halted, bp_hit, done;
    logic [3:0] icount;
    logic       loop_en = 1'b0;

    int checks = 0;
    int errors = 0;

    cpu_runctl #(.PC_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .pc(pc_m), .pc_next(pc_next),
        .pc_we_in(pc_we_in), .reg_we_in(reg_we_in), .mem_we_in(mem_we_in),
        .pc_we_out(pc_we_out), .reg_we_out(reg_we_out),
        .mem_we_out(mem_we_out),
        .state(state), .halted(halted), .bp_hit(bp_hit), .done(done),
        .icount(icount)
    );

    always #5 clk = ~clk;

    // program model: sequential pc, optional jump-to-self at 0x0A
    assign pc_next   = (loop_en && pc_m == 8'h0A) ? pc_m : pc_m + 8'd1;
    assign pc_we_in  = 1'b1;
    assign reg_we_in = 1'b1;
    assign mem_we_in = pc_m[0];

    always @(posedge clk or negedge rst) begin
        if (!rst)
            pc_m <= 8'h00;
        else if (pc_we_out)
            pc_m <= pc_next;
    end

    typedef struct {
        logic       run, halt, step;
        logic [1:0] st;
        logic       we;
        logic [3:0] ic;
        logic       hit;
    } vec_t;

    typedef struct {
        int         row;
        logic [1:0] st;
        logic       we;
        logic [3:0] ic;
        logic       hit;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run_req = 0; halt_req = 0; step_req = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   n;
        vecs[0]  = '{0,0,0, 2'd0, 0, 4'd0, 0};
        vecs[1]  = '{0,0,1, 2'd0, 0, 4'd0, 0};
        vecs[2]  = '{0,0,0, 2'd2, 1, 4'd0, 0};
        vecs[3]  = '{0,0,0, 2'd0, 0, 4'd1, 0};
        vecs[4]  = '{1,0,1, 2'd0, 0, 4'd1, 0};
        vecs[5]  = '{0,0,0, 2'd1, 1, 4'd1, 0};
        vecs[6]  = '{0,0,0, 2'd1, 1, 4'd2, 0};
        vecs[7]  = '{0,1,0, 2'd1, 1, 4'd3, 0};
        vecs[8]  = '{0,1,0, 2'd0, 0, 4'd4, 0};
        vecs[9]  = '{0,0,1, 2'd0, 0, 4'd4, 0};
        vecs[10] = '{0,0,0, 2'd2, 1, 4'd4, 0};
        vecs[11] = '{0,0,0, 2'd0, 0, 4'd5, 0};

        // reset state while rst is held low
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_halted", halted, 1);
        check("rst_done", done, 0);
        check("rst_icount", icount, 0);
        check("rst_pc_we", pc_we_out, 0);
        check("rst_reg_we", reg_we_out, 0);
        do_reset();

        // table: step, run+step priority, halt, halt ignored in HALT
        for (int i = 0; i < 12; i++) begin
            run_req  = vecs[i].run;
            halt_req = vecs[i].halt;
            step_req = vecs[i].step;
            sb.push_back('{i, vecs[i].st, vecs[i].we, vecs[i].ic,
                           vecs[i].hit});
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("row%0d_state", e.row), state, e.st);
            check($sformatf("row%0d_we", e.row), pc_we_out, e.we);
            check($sformatf("row%0d_icount", e.row), icount, e.ic);
            check($sformatf("row%0d_bphit", e.row), bp_hit, e.hit);
            tick();
        end
        run_req = 0; halt_req = 0; step_req = 0;

        // run 10 cycles then halt: 11 instructions
        do_reset();
        run_req = 1; tick(); run_req = 0;
        repeat (10) tick();
        halt_req = 1; tick(); halt_req = 0;
        @(negedge clk);
        check("runhalt_icount", icount, 11);
        check("runhalt_halted", halted, 1);
        check("runhalt_we", pc_we_out, 0);
        check("runhalt_mem_we", mem_we_out | reg_we_out, 0);

        // breakpoint at 0x05
        do_reset();
        bp_en = 1; bp_addr = 8'h05;
        run_req = 1; tick(); run_req = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pc_m == 8'h05) check("bp_nowrite", pc_we_out, 0);
            if (halted) break;
            tick();
        end
        check("bp_halted", halted, 1);
        check("bp_pc", pc_m, 5);
        check("bp_hit", bp_hit, 1);
        check("bp_icount", icount, 5);
        tick();
        run_req = 1; tick(); run_req = 0;
        @(negedge clk);
        check("bp_resume_state", state, 1);
        check("bp_resume_we", pc_we_out, 1);
        check("bp_resume_hit", bp_hit, 0);
        tick();
        check("bp_resume_pc", pc_m, 6);
        halt_req = 1; tick(); halt_req = 0;
        bp_en = 0;

        // termination by jump-to-self at 0x0A
        do_reset();
        loop_en = 1;
        run_req = 1; tick(); run_req = 0;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) break;
            tick();
        end
        check("term_done", done, 1);
        check("term_state", state, 3);
        check("term_halted", halted, 1);
        check("term_icount", icount, 11);
        check("term_pc", pc_m, 10);
        tick();
        run_req = 1; step_req = 1;
        @(negedge clk);
        check("term_ign_we", pc_we_out, 0);
        tick();
        run_req = 0; step_req = 0;
        @(negedge clk);
        check("term_ign_state", state, 3);
        check("term_ign_icount", icount, 11);
        loop_en = 0;

        // breakpoint beats halt_req in the same cycle
        do_reset();
        bp_en = 1; bp_addr = 8'h02;
        run_req = 1; tick(); run_req = 0;
        for (n = 0; n < 10; n++) begin
            if (pc_m == 8'h02) break;
            tick();
        end
        check("prio_reach", pc_m, 2);
        halt_req = 1;
        @(negedge clk);
        check("prio_we", pc_we_out, 0);
        tick();
        halt_req = 0;
        @(negedge clk);
        check("prio_state", state, 0);
        check("prio_hit", bp_hit, 1);
        check("prio_icount", icount, 2);
        bp_en = 0;

        // saturation at 15, then asynchronous reset mid-RUN
        do_reset();
        run_req = 1; tick(); run_req = 0;
        repeat (20) tick();
        halt_req = 1; tick(); halt_req = 0;
        tick();
        check("sat_icount", icount, 15);
        run_req = 1; tick(); run_req = 0;
        repeat (3) tick();
        check("arst_pre_we", pc_we_out, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_we", pc_we_out, 0);
        check("arst_state", state, 0);
        check("arst_icount", icount, 0);
        check("arst_hit", bp_hit, 0);
        tick();
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
